mem_loader: RTL and testbench
=============================

# mem_loader

Program loader for the pd-series core: accepts a byte stream and writes it into `memory` through the same write port that `fetch` leaves idle. Each byte group is assembled little-endian into DWIDTH-bit words, written to consecutive addresses from BASE_ADDR, and completion is reported. `hold_o` stalls fetch while a load is in progress.

## Interface
- AWIDTH, 32, address width; matches `memory`/`fetch`
- DWIDTH, 32, data word width; multiple of 8; BPW = DWIDTH/8 bytes per word
- BASE_ADDR, 32'h0100_0000, address of first written word
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- start_i  input  1  begin a load; sampled only in IDLE and DONE
- length_i  input  AWIDTH  number of words to load; latched with start_i
- byte_valid_i  input  1  byte_i holds a valid byte
- byte_i  input  8  stream byte
- byte_ready_o  output  1  loader can accept a byte this cycle
- addr_o  output  AWIDTH  memory address (to `memory` addr_i via top-level mux)
- data_o  output  DWIDTH  assembled word (to `memory` data_i)
- write_en_o  output  1  one-cycle write strobe
- read_en_o  output  1  tied 0
- hold_o  output  1  high while busy; top level gates fetch and the address mux with it
- done_o  output  1  load complete; sticky until the next accepted start_i or reset

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready_o=0, hold_o=0. start_i=1 latches length_i into words_left and sets addr=BASE_ADDR and byte_cnt=0.
  - length_i==0: go to DONE.
  - Otherwise: go to COLLECT.
- COLLECT: byte_ready_o=1, hold_o=1.
  - Transfer when byte_valid_i && byte_ready_o. byte_i goes into word bits [8*byte_cnt +: 8], then byte_cnt increments.
  - The transfer with byte_cnt==BPW-1 moves to WRITE and clears byte_cnt.
  - byte_valid_i low stalls indefinitely with no timeout.
- WRITE: write_en_o=1, addr_o=addr, data_o=word, byte_ready_o=0, hold_o=1.
  - Next cycle: addr += BPW (wraps modulo 2^AWIDTH), words_left -= 1.
  - words_left reaching 0 goes to DONE; otherwise back to COLLECT.
- DONE: done_o=1, hold_o=0, byte_ready_o=0. start_i=1 clears done_o and reloads exactly as from IDLE, including the length_i==0 case.
- start_i is ignored in COLLECT and WRITE.
- Bytes presented outside COLLECT are not consumed; the source must hold them until byte_ready_o.
- Partial words are never written. A load aborted by reset leaves already-written words in memory.
- write_en_o is asserted only in WRITE. read_en_o is always 0.

## Timing
- Reset (asynchronous assert) sets all outputs to 0 in the same cycle: byte_ready_o, write_en_o, hold_o, done_o, read_en_o = 0 and addr_o = data_o = 0.
- After reset: state=IDLE, words_left=0, byte_cnt=0.
- Reset mid-load returns to IDLE immediately. hold_o drops without waiting for a clock.
- start_i accepted at edge T: state=COLLECT and byte_ready_o=1 during cycle T+1.
- Last byte of a word accepted at edge N: write_en_o high during cycle N+1, byte_ready_o low that cycle.
- Throughput: one word per BPW+1 cycles under a continuous byte stream, because of one bubble per word.
- Final word written in cycle N+1: done_o=1 and hold_o=0 from cycle N+2.
- addr_o and data_o are registered and valid for the entire write_en_o cycle; they are 0 outside WRITE.
- No combinational path from inputs to outputs. byte_ready_o depends only on state.

## Test plan
- Reset: assert rst mid-COLLECT after 2 bytes -> all outputs 0 immediately, no write_en_o. After release, a new load starts at BASE_ADDR with byte_cnt=0.
- Single word: start_i with length_i=1, bytes 0x13,0x05,0x10,0x00 on consecutive cycles -> one write_en_o pulse, addr_o=0x0100_0000, data_o=0x0010_0513, done_o two cycles after the last byte.
- Multi-word with gaps: length_i=3, byte_valid_i deasserted at random cycles -> writes to 0x0100_0000, 0x0100_0004, 0x0100_0008 with correct little-endian data. No write while stalled; hold_o high throughout.
- Zero length and restart: length_i=0 -> DONE next cycle, no write. Then start_i with length_i=1 from DONE -> done_o clears and a new load runs.
- Ignored start and wrap: start_i pulsed during COLLECT -> no effect on words_left. Separately, BASE_ADDR=32'hFFFF_FFFC with length_i=2 -> writes at 0xFFFF_FFFC then 0x0000_0000.
- Back-pressure: byte_valid_i held high with a changing byte_i across the WRITE bubble -> the byte present during WRITE is not consumed and is accepted as byte 0 of the next word.

Source files
------------

// File: rtl/mem_loader.sv
// Program loader: packs an incoming byte stream little-endian into DWIDTH-bit
// words and writes them to consecutive addresses from BASE_ADDR, stalling fetch while busy.
module mem_loader #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] length_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic              hold_o,
  output logic              done_o
);

  localparam int BPW = DWIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic [AWIDTH-1:0] words_left;
  logic [AWIDTH-1:0] addr;
  logic [CW-1:0]     byte_cnt;
  logic [DWIDTH-1:0] word;

  // NOTE: every register here uses <= so all branches see the pre-edge values of
  // state, byte_cnt and words_left; blocking assignments would leak updates between them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      words_left <= '0;
      addr       <= '0;
      byte_cnt   <= '0;
      word       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            words_left <= length_i;
            addr       <= BASE_ADDR;
            byte_cnt   <= '0;
            state      <= (length_i == '0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (byte_valid_i) begin
            word[8*byte_cnt +: 8] <= byte_i;
            if (byte_cnt == CW'(BPW - 1)) begin
              byte_cnt <= '0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        WRITE: begin
          addr       <= addr + AWIDTH'(BPW);
          words_left <= words_left - AWIDTH'(1);
          state      <= (words_left == AWIDTH'(1)) ? DONE : COLLECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  assign byte_ready_o = (state == COLLECT);
  assign write_en_o   = (state == WRITE);
  assign hold_o       = (state == COLLECT) || (state == WRITE);
  assign done_o       = (state == DONE);
  assign read_en_o    = 1'b0;
  assign addr_o       = (state == WRITE) ? addr : '0;
  assign data_o       = (state == WRITE) ? word : '0;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized scoreboard bench for mem_loader: two instances share stimulus, one at the
// default base and one at 0xFFFF_FFFC so every multi-word load also exercises address wrap.
module tb_mem_loader;

  localparam int          BPW    = 4;
  localparam logic [31:0] BASE_A = 32'h0100_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
  localparam int          BUDGET = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] length_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;

  logic        a_ready, a_we, a_re, a_hold, a_done;
  logic [31:0] a_addr, a_data;
  logic        b_ready, b_we, b_re, b_hold, b_done;
  logic [31:0] b_addr, b_data;

  mem_loader u_a (
    .clk(clk), .rst(rst), .start_i(start_i), .length_i(length_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(a_ready),
    .addr_o(a_addr), .data_o(a_data), .write_en_o(a_we), .read_en_o(a_re),
    .hold_o(a_hold), .done_o(a_done)
  );

  mem_loader #(.BASE_ADDR(BASE_B)) u_b (
    .clk(clk), .rst(rst), .start_i(start_i), .length_i(length_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(b_ready),
    .addr_o(b_addr), .data_o(b_data), .write_en_o(b_we), .read_en_o(b_re),
    .hold_o(b_hold), .done_o(b_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (a_we) begin
      if (exp_a.size() == 0) check("a_unexpected_write", 32'(a_addr), 32'hDEAD_0000);
      else begin
        e = exp_a.pop_front();
        check("a_addr", a_addr, e.addr);
        check("a_data", a_data, e.data);
        check("a_read_en", 32'(a_re), 0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (b_we) begin
      if (exp_b.size() == 0) check("b_unexpected_write", 32'(b_addr), 32'hDEAD_0000);
      else begin
        e = exp_b.pop_front();
        check("b_addr", b_addr, e.addr);
        check("b_data", b_data, e.data);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(a_ready), 0);
    check({tag, "_we"},    32'(a_we),    0);
    check({tag, "_hold"},  32'(a_hold),  0);
    check({tag, "_done"},  32'(a_done),  0);
    check({tag, "_re"},    32'(a_re),    0);
    check({tag, "_addr"},  a_addr,       0);
    check({tag, "_data"},  a_data,       0);
    check({tag, "_b_hold"}, 32'(b_hold), 0);
  endtask

  // Starts a load of len words, streams the bytes (optionally with gaps and spurious
  // start pulses) and checks the write/done timing around the final word.
  task automatic run_load(input int len, input bit gaps, input bit noise,
                          input bit use_first, input logic [31:0] first_word);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    int          idx;
    int          cycles;
    @(negedge clk);
    start_i  = 1'b1;
    length_i = len;
    @(negedge clk);
    start_i  = 1'b0;
    length_i = $urandom;
    if (len == 0) begin
      check("zero_done",  32'(a_done),  1);
      check("zero_hold",  32'(a_hold),  0);
      check("zero_ready", 32'(a_ready), 0);
      return;
    end
    check("start_ready", 32'(a_ready), 1);
    check("start_hold",  32'(a_hold),  1);
    check("start_done",  32'(a_done),  0);
    for (int wi = 0; wi < len; wi++) begin
      w = (use_first && wi == 0) ? first_word : $urandom;
      exp_a.push_back('{addr: BASE_A + BPW * wi, data: w});
      exp_b.push_back('{addr: BASE_B + BPW * wi, data: w});
      for (int k = 0; k < BPW; k++) bytes.push_back(w[8*k +: 8]);
    end
    idx    = 0;
    cycles = 0;
    while (idx < bytes.size()) begin
      byte_i       = bytes[idx];
      byte_valid_i = !(gaps && $urandom_range(0, 2) == 0);
      start_i      = noise && ($urandom_range(0, 3) == 0);
      length_i     = $urandom_range(1, 9);
      check("busy_hold", 32'(a_hold), 1);
      if (byte_valid_i && a_ready) idx++;
      cycles++;
      if (cycles > BUDGET) begin
        check("byte_timeout", 32'(idx), 32'(bytes.size()));
        break;
      end
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
    check("last_write_en", 32'(a_we),    1);
    check("last_ready",    32'(a_ready), 0);
    @(negedge clk);
    check("final_done", 32'(a_done), 1);
    check("final_hold", 32'(a_hold), 0);
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    length_i     = '0;
    byte_valid_i = 1'b0;
    byte_i       = '0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_load(1, 1'b0, 1'b0, 1'b1, 32'h0010_0513);
    run_load(3, 1'b1, 1'b0, 1'b0, '0);
    run_load(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("done_sticky", 32'(a_done), 1);
    run_load(1, 1'b0, 1'b0, 1'b0, '0);
    run_load(3, 1'b1, 1'b1, 1'b0, '0);
    run_load(2, 1'b0, 1'b0, 1'b0, '0);
    run_load(4, 1'b0, 1'b0, 1'b0, '0);

    // Abort a load after two bytes: nothing may be written, outputs clear asynchronously.
    @(negedge clk);
    start_i  = 1'b1;
    length_i = 2;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("abort_ready", 32'(a_ready), 1);
      byte_valid_i = 1'b1;
      byte_i       = 8'($urandom);
      @(negedge clk);
    end
    byte_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_load(1, 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 6; i++)
      run_load($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);

    repeat (3) @(negedge clk);
    check("a_queue_empty", 32'(exp_a.size()), 0);
    check("b_queue_empty", 32'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
